game_flow_controller: RTL

Game-level sequencer for the 8x8 LED brick-breaker. It owns the serve / play / miss / game-over / win state machine, the life register and the two-digit BCD score. It generates the ball-step and bonus-launch strobes that pace the ball/brick engine. It sits between the button/divider front end and the engine, and its outputs feed both the engine and the LED/7-segment display scanner.

---
 rtl/game_flow_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/game_flow_controller.sv
// Game-level sequencer: serve/play/miss/over/won FSM, lives, saturating BCD score, ball pacing.
// Optional bonus-ball launcher is built only when GAME_BONUS_EN is defined.
module game_flow_controller #(
   parameter int BALL_DIV     = 3,
   parameter int BONUS_PERIOD = 50
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       throw,
   input  logic       ball_lost,
   input  logic [1:0] brick_hit,
   input  logic       bricks_zero,
   input  logic       bonus_active,
   output logic       ball_step,
   output logic       bonus_launch,
   output logic       serve_hold,
   output logic       respawn,
   output logic       field_reload,
   output logic [2:0] life,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic       game_over,
   output logic       game_won
);

   typedef enum logic [2:0] {
      S_INIT,
      S_SERVE,
      S_PLAY,
      S_MISS,
      S_OVER,
      S_WON
   } state_t;

   localparam int BDW = $clog2(BALL_DIV + 1);
   localparam logic [BDW-1:0] BD_LAST = BDW'(BALL_DIV - 1);

   state_t         state;
   logic [BDW-1:0] ball_div;
   logic           qtick;
   logic [1:0]     hit_eff;
   logic [4:0]     ones_sum;
   logic [3:0]     ones_next;
   logic [3:0]     tens_next;
   logic [2:0]     life_next;

`ifdef GAME_BONUS_EN
   localparam int BNW = $clog2(BONUS_PERIOD);
   localparam logic [BNW-1:0] BN_LAST = BNW'(BONUS_PERIOD - 1);
   logic [BNW-1:0] bonus_cnt;
`else
   logic unused_bonus_active;
   assign unused_bonus_active = bonus_active;
   assign bonus_launch        = 1'b0;
`endif

   assign qtick     = tick & start;
   assign hit_eff   = (brick_hit == 2'd3) ? 2'd2 : brick_hit;
   assign ones_sum  = {1'b0, score_ones} + {3'b000, hit_eff};
   assign life_next = {life[1:0], 1'b0};

   // Saturating BCD add: a carry out of 9x pins the score at 99.
   always_comb begin
      ones_next = score_ones;
      tens_next = score_tens;
      if (ones_sum > 5'd9) begin
         if (score_tens == 4'd9) begin
            ones_next = 4'd9;
            tens_next = 4'd9;
         end else begin
            ones_next = 4'(ones_sum - 5'd10);
            tens_next = score_tens + 4'd1;
         end
      end else begin
         ones_next = ones_sum[3:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= S_INIT;
         ball_div     <= '0;
         ball_step    <= 1'b0;
         serve_hold   <= 1'b0;
         respawn      <= 1'b0;
         field_reload <= 1'b0;
         life         <= 3'b111;
         score_ones   <= '0;
         score_tens   <= '0;
         game_over    <= 1'b0;
         game_won     <= 1'b0;
`ifdef GAME_BONUS_EN
         bonus_cnt    <= '0;
         bonus_launch <= 1'b0;
`endif
      end else begin
         ball_step    <= 1'b0;
         respawn      <= 1'b0;
         field_reload <= 1'b0;
`ifdef GAME_BONUS_EN
         bonus_launch <= 1'b0;
`endif
         if (qtick) begin
            case (state)
               S_INIT: begin
                  field_reload <= 1'b1;
                  respawn      <= 1'b1;
                  life         <= 3'b111;
                  score_ones   <= '0;
                  score_tens   <= '0;
                  ball_div     <= '0;
`ifdef GAME_BONUS_EN
                  bonus_cnt    <= '0;
`endif
                  serve_hold   <= 1'b1;
                  game_over    <= 1'b0;
                  game_won     <= 1'b0;
                  state        <= S_SERVE;
               end
               S_SERVE: begin
                  if (throw) begin
                     serve_hold <= 1'b0;
                     ball_div   <= '0;
                     state      <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (ball_div == BD_LAST) begin
                     ball_step <= 1'b1;
                     ball_div  <= '0;
                  end else begin
                     ball_div <= ball_div + 1'b1;
                  end
                  score_ones <= ones_next;
                  score_tens <= tens_next;
`ifdef GAME_BONUS_EN
                  if (!bonus_active) begin
                     if (bonus_cnt == BN_LAST) begin
                        bonus_launch <= 1'b1;
                        bonus_cnt    <= '0;
                     end else begin
                        bonus_cnt <= bonus_cnt + 1'b1;
                     end
                  end
`endif
                  // Exits override the bonus counter update above (later NBA wins).
                  if (bricks_zero) begin
                     game_won <= 1'b1;
                     state    <= S_WON;
`ifdef GAME_BONUS_EN
                     bonus_cnt <= '0;
`endif
                  end else if (ball_lost) begin
                     life <= life_next;
                     if (life_next == 3'b000) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                     end else begin
                        state <= S_MISS;
                     end
`ifdef GAME_BONUS_EN
                     bonus_cnt <= '0;
`endif
                  end
               end
               S_MISS: begin
                  respawn    <= 1'b1;
                  serve_hold <= 1'b1;
                  state      <= S_SERVE;
               end
               S_OVER, S_WON: begin
                  if (throw) begin
                     game_over <= 1'b0;
                     game_won  <= 1'b0;
                     state     <= S_INIT;
                  end
               end
               default: state <= S_INIT;
            endcase
         end
      end
   end

endmodule
